// File: rtl/syn_global_pkg.sv
// Shared types and constants for the local-bus fabric: FSM state encoding,
// local register offsets and the error/unmapped read pattern.
package syn_global_pkg;

  typedef enum logic [1:0] {
    LB_FAB_IDLE = 2'd0,
    LB_FAB_WAIT = 2'd1,
    LB_FAB_RESP = 2'd2
  } lb_fab_state_t;

  localparam int LB_FAB_SRST_OFF   = 0;
  localparam int LB_FAB_TOCNT_OFF  = 1;
  localparam int LB_FAB_STATUS_OFF = 2;

  // Wide enough for any DATA_W in use; callers slice the low DATA_W bits.
  localparam logic [1023:0] LB_FAB_ERR_DATA = '1;

endpackage

// File: rtl/syn_lb_srst_gen.sv
// Per-slave soft-reset stretcher: a trigger starts (or restarts) a pulse of
// RST_PULSE_W cycles; the output is held high while the fabric is in reset.
module syn_lb_srst_gen #(
  parameter int RST_PULSE_W = 4
) (
  input  logic clk_ir,
  input  logic rst_sync,
  input  logic trig,
  output logic srst
);

  localparam int CNT_W = (RST_PULSE_W > 1) ? $clog2(RST_PULSE_W) : 1;

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of pulse cycles still to come after the current one
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      srst <= 1'b1;
      cnt  <= '0;
    end else if (trig) begin
      srst <= 1'b1;
      cnt  <= CNT_W'(RST_PULSE_W - 1);
    end else if (cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
    end else begin
      srst <= 1'b0;
    end
  end

endmodule

// File: rtl/syn_lb_fabric.sv
// Local-bus address-decode fabric: one master port fanned out to NUM_SLAVES
// slaves by block code, one outstanding transaction, registered responses.
// Optional slave timeout and TO_CNT register: SYN_LB_FABRIC_TIMEOUT_EN.
module syn_lb_fabric
  import syn_global_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int CODE_W      = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int RST_PULSE_W = 4
) (
  input  logic                         clk_ir,
  input  logic                         rst_sync,
  input  logic                         m_rd_en,
  input  logic                         m_wr_en,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wr_data,
  output logic                         m_wr_valid,
  output logic                         m_rd_valid,
  output logic [DATA_W-1:0]            m_rd_data,
  output logic [NUM_SLAVES-1:0]        s_rd_en,
  output logic [NUM_SLAVES-1:0]        s_wr_en,
  output logic [ADDR_W-CODE_W-1:0]     s_addr,
  output logic [DATA_W-1:0]            s_wr_data,
  input  logic [NUM_SLAVES-1:0]        s_wr_valid,
  input  logic [NUM_SLAVES-1:0]        s_rd_valid,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
  output logic [NUM_SLAVES-1:0]        srst_o
);

  localparam int LOC_W = ADDR_W - CODE_W;
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  lb_fab_state_t state, state_nxt;

  logic [CODE_W-1:0]     code;
  logic [LOC_W-1:0]      loc;
  logic                  req, is_slave, is_local, launch;
  logic [NUM_SLAVES-1:0] code_onehot, sel_onehot;
  logic [SEL_W-1:0]      sel;
  logic                  sel_wr;
  logic                  hit_valid, timeout;
  logic [15:0]           to_rd;
  logic [1:0]            status;
  logic [DATA_W-1:0]     loc_rd;

  logic                  rsp_rd, rsp_wr;
  logic [DATA_W-1:0]     rsp_data;
  logic [NUM_SLAVES-1:0] stb_rd, stb_wr, srst_trig;
  logic                  drop_set, spur_set;
  logic [1:0]            st_clr;

  assign code        = m_addr[ADDR_W-1 -: CODE_W];
  assign loc         = m_addr[LOC_W-1:0];
  assign req         = m_rd_en | m_wr_en;
  assign is_slave    = int'(code) < NUM_SLAVES;
  assign is_local    = code == {CODE_W{1'b1}};
  assign launch      = (state == LB_FAB_IDLE) && req && is_slave;
  assign code_onehot = NUM_SLAVES'(1) << code;
  assign sel_onehot  = NUM_SLAVES'(1) << sel;
  // Only the valid matching the outstanding direction completes the transaction
  assign hit_valid   = sel_wr ? s_wr_valid[sel] : s_rd_valid[sel];

`ifdef SYN_LB_FABRIC_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] tmr;
  logic [15:0]      to_cnt;
  logic             to_clr;

  assign timeout = (state == LB_FAB_WAIT) && !hit_valid && (tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign to_clr  = (state == LB_FAB_IDLE) && m_wr_en && is_local && (loc == LOC_W'(LB_FAB_TOCNT_OFF));
  assign to_rd   = to_cnt;

  always_ff @(posedge clk_ir) begin
    if (rst_sync || state != LB_FAB_WAIT) tmr <= '0;
    else                                  tmr <= tmr + TMR_W'(1);
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync || to_clr)                 to_cnt <= '0;
    else if (timeout && to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
  end
`else
  assign timeout = 1'b0;
  assign to_rd   = 16'h0;
`endif

  always_comb begin
    loc_rd = '0;
    if (loc == LOC_W'(LB_FAB_TOCNT_OFF))  loc_rd = {{(DATA_W-16){1'b0}}, to_rd};
    if (loc == LOC_W'(LB_FAB_STATUS_OFF)) loc_rd = {{(DATA_W-2){1'b0}}, status};
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync) state <= LB_FAB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LB_FAB_IDLE: if (req) state_nxt = is_slave ? LB_FAB_WAIT : LB_FAB_RESP;
      LB_FAB_WAIT: if (hit_valid || timeout) state_nxt = LB_FAB_RESP;
      LB_FAB_RESP: state_nxt = LB_FAB_IDLE;
      default:     state_nxt = LB_FAB_IDLE;
    endcase
  end

  // Next values of every registered output and sticky flag
  always_comb begin
    rsp_rd    = 1'b0;
    rsp_wr    = 1'b0;
    rsp_data  = '0;
    stb_rd    = '0;
    stb_wr    = '0;
    srst_trig = '0;
    drop_set  = 1'b0;
    spur_set  = 1'b0;
    st_clr    = '0;
    case (state)
      LB_FAB_IDLE: begin
        if (req) begin
          if (is_slave) begin
            stb_wr = m_wr_en ? code_onehot : '0;
            stb_rd = m_wr_en ? '0 : code_onehot;
          end else if (is_local) begin
            rsp_wr   = m_wr_en;
            rsp_rd   = ~m_wr_en;
            rsp_data = loc_rd;
            if (m_wr_en && loc == LOC_W'(LB_FAB_SRST_OFF))   srst_trig = m_wr_data[NUM_SLAVES-1:0];
            if (m_wr_en && loc == LOC_W'(LB_FAB_STATUS_OFF)) st_clr    = m_wr_data[1:0];
          end else begin
            rsp_wr   = m_wr_en;
            rsp_rd   = ~m_wr_en;
            rsp_data = LB_FAB_ERR_DATA[DATA_W-1:0];
          end
        end
      end
      LB_FAB_WAIT: begin
        drop_set = req;
        spur_set = |((s_rd_valid | s_wr_valid) & ~sel_onehot);
        if (hit_valid) begin
          rsp_wr   = sel_wr;
          rsp_rd   = ~sel_wr;
          rsp_data = s_rd_data[sel*DATA_W +: DATA_W];
        end else if (timeout) begin
          rsp_wr   = sel_wr;
          rsp_rd   = ~sel_wr;
          rsp_data = LB_FAB_ERR_DATA[DATA_W-1:0];
        end
      end
      LB_FAB_RESP: drop_set = req;
      default: ;
    endcase
  end

  // Registered output stage
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      m_rd_valid <= 1'b0;
      m_wr_valid <= 1'b0;
      m_rd_data  <= '0;
      s_rd_en    <= '0;
      s_wr_en    <= '0;
      s_addr     <= '0;
      s_wr_data  <= '0;
      sel        <= '0;
      sel_wr     <= 1'b0;
      status     <= '0;
    end else begin
      m_rd_valid <= rsp_rd;
      m_wr_valid <= rsp_wr;
      if (rsp_rd) m_rd_data <= rsp_data;
      s_rd_en    <= stb_rd;
      s_wr_en    <= stb_wr;
      if (launch) begin
        s_addr    <= loc;
        s_wr_data <= m_wr_data;
        sel       <= code[SEL_W-1:0];
        sel_wr    <= m_wr_en;
      end
      status     <= (status & ~st_clr) | {spur_set, drop_set};
    end
  end

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_srst
    syn_lb_srst_gen #(.RST_PULSE_W(RST_PULSE_W)) u_srst (
      .clk_ir  (clk_ir),
      .rst_sync(rst_sync),
      .trig    (srst_trig[i]),
      .srst    (srst_o[i])
    );
  end

endmodule

// File: tb/tb_syn_lb_fabric.sv
// Randomised scoreboard bench for syn_lb_fabric: a driver pushes expected
// responses (cycle, kind, data) and a negedge monitor pops and compares them.
module tb_syn_lb_fabric;

  localparam int NS = 4, DW = 32, AW = 12, CW = 4, TO = 16, PW = 4;
`ifdef SYN_LB_FABRIC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAXD = TO_EN ? TO - 1 : 20;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic              clk_ir = 1'b0, rst_sync = 1'b1;
  logic              m_rd_en = 0, m_wr_en = 0;
  logic [AW-1:0]     m_addr = '0;
  logic [DW-1:0]     m_wr_data = '0;
  logic              m_wr_valid, m_rd_valid;
  logic [DW-1:0]     m_rd_data;
  logic [NS-1:0]     s_rd_en, s_wr_en, srst_o;
  logic [AW-CW-1:0]  s_addr;
  logic [DW-1:0]     s_wr_data;
  logic [NS-1:0]     s_wr_valid = '0, s_rd_valid = '0;
  logic [NS*DW-1:0]  s_rd_data = '0;

  syn_lb_fabric #(.NUM_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW), .CODE_W(CW),
                  .TIMEOUT_CYC(TO), .RST_PULSE_W(PW)) dut (
    .clk_ir(clk_ir), .rst_sync(rst_sync), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_wr_valid(m_wr_valid),
    .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data), .s_rd_en(s_rd_en),
    .s_wr_en(s_wr_en), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_wr_valid(s_wr_valid), .s_rd_valid(s_rd_valid), .s_rd_data(s_rd_data),
    .srst_o(srst_o));

  always #5 clk_ir = ~clk_ir;

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk_ir) begin
    cyc   <= cyc + 1;
    rst_q <= rst_sync;
  end

  typedef struct {int cyc; bit wr; logic [31:0] data;} exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  // reference model state
  int          srst_s[NS] = '{default: 1};
  int          srst_e[NS] = '{default: 0};
  logic [15:0] to_m = 0;
  bit          drop_m = 0, spur_m = 0;
  int          stb_cyc = -10;
  logic [NS-1:0] stb_mask = '0;
  bit          stb_wr = 0;
  logic [7:0]  stb_addr = '0;
  logic [31:0] stb_wdata = '0;

  task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin srst_s[i] = 1; srst_e[i] = 0; end
    to_m = 0; drop_m = 0; spur_m = 0;
  endtask

  // Monitor: continuous output checks plus scoreboard pop on every response
  always @(negedge clk_ir) begin
    logic [NS-1:0] es, erd, ewr;
    exp_t e;
    for (int i = 0; i < NS; i++) es[i] = rst_q || (cyc >= srst_s[i] && cyc <= srst_e[i]);
    chk("srst_o", srst_o === es, 64'(srst_o), 64'(es));
    erd = (cyc == stb_cyc && !stb_wr) ? stb_mask : '0;
    ewr = (cyc == stb_cyc &&  stb_wr) ? stb_mask : '0;
    chk("s_rd_en", s_rd_en === erd, 64'(s_rd_en), 64'(erd));
    chk("s_wr_en", s_wr_en === ewr, 64'(s_wr_en), 64'(ewr));
    if (cyc == stb_cyc) begin
      chk("s_addr", s_addr === stb_addr, 64'(s_addr), 64'(stb_addr));
      if (stb_wr) chk("s_wr_data", s_wr_data === stb_wdata, 64'(s_wr_data), 64'(stb_wdata));
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("resp_missing", 1'b0, 64'(cyc), 64'(q[0].cyc));
      void'(q.pop_front());
    end
    if (m_rd_valid !== 1'b0 || m_wr_valid !== 1'b0) begin
      if (q.size() == 0) chk("resp_unexpected", 1'b0, 64'({m_wr_valid, m_rd_valid}), 64'(0));
      else begin
        e = q.pop_front();
        chk("resp_cyc", cyc == e.cyc, 64'(cyc), 64'(e.cyc));
        chk("resp_kind", {m_wr_valid, m_rd_valid} === {e.wr, !e.wr},
            64'({m_wr_valid, m_rd_valid}), 64'({e.wr, !e.wr}));
        if (!e.wr) chk("rd_data", m_rd_data === e.data, 64'(m_rd_data), 64'(e.data));
      end
    end
  end

  // One master transaction from IDLE; slave answers dly cycles after its strobe
  task automatic txn(input bit wr, input bit both, input logic [11:0] addr, input logic [31:0] wdata,
                     input int dly, input logic [31:0] sdata, input bit silent);
    int t, v, r, code;
    logic [7:0] loc;
    exp_t e;
    t = cyc; v = 0; code = int'(addr[11:8]); loc = addr[7:0];
    m_rd_en = !wr || both; m_wr_en = wr; m_addr = addr; m_wr_data = wdata;
    e.wr = wr; e.data = ERR;
    if (code < NS) begin
      stb_cyc = t + 1; stb_mask = NS'(1 << code); stb_wr = wr; stb_addr = loc; stb_wdata = wdata;
      if (silent) begin
        r = t + 1 + TO;
        if (to_m != 16'hFFFF) to_m++;
      end else begin
        v = t + 1 + dly; r = v + 1; e.data = sdata;
      end
    end else if (code == 15) begin
      r = t + 1;
      if (wr) begin
        if (loc == 0) begin
          for (int i = 0; i < NS; i++)
            if (wdata[i]) begin
              if (!(srst_s[i] <= t && srst_e[i] >= t)) srst_s[i] = t + 1;
              srst_e[i] = t + PW;
            end
        end else if (loc == 1) to_m = 0;
        else if (loc == 2) begin
          if (wdata[0]) drop_m = 0;
          if (wdata[1]) spur_m = 0;
        end
      end else e.data = (loc == 1) ? {16'h0, to_m} : (loc == 2) ? {30'h0, spur_m, drop_m} : 32'h0;
    end else r = t + 1;
    e.cyc = r;
    q.push_back(e);
    @(negedge clk_ir);
    m_rd_en = 0; m_wr_en = 0;
    if (code < NS && !silent) begin
      while (cyc < v) @(negedge clk_ir);
      s_rd_data = {$urandom, $urandom, $urandom, $urandom};
      s_rd_data[code*DW +: DW] = sdata;
      if (wr) s_wr_valid[code] = 1'b1;
      else    s_rd_valid[code] = 1'b1;
      @(negedge clk_ir);
      s_rd_valid = '0; s_wr_valid = '0;
    end
    while (cyc < r + 1) @(negedge clk_ir);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    exp_t e;
    repeat (3) @(negedge clk_ir);
    chk("rst_m_rd_valid", m_rd_valid === 1'b0, 64'(m_rd_valid), 0);
    chk("rst_m_wr_valid", m_wr_valid === 1'b0, 64'(m_wr_valid), 0);
    chk("rst_m_rd_data", m_rd_data === '0, 64'(m_rd_data), 0);
    chk("rst_s_addr", s_addr === '0, 64'(s_addr), 0);
    chk("rst_s_wr_data", s_wr_data === '0, 64'(s_wr_data), 0);
    rst_sync = 1'b0;
    repeat (2) @(negedge clk_ir);

    txn(0, 0, 12'h210, 0, 3, 32'h1234_5678, 0);
    txn(1, 0, 12'hF00, 32'h5, 0, 0, 0);
    @(negedge clk_ir);
    txn(1, 0, 12'hF00, 32'h5, 0, 0, 0);
    repeat (6) @(negedge clk_ir);
    if (TO_EN) begin
      txn(0, 0, 12'h1AB, 0, 0, 0, 1);
      txn(0, 0, 12'hF01, 0, 0, 0, 0);
      txn(1, 0, 12'hF01, 32'h9, 0, 0, 0);
      txn(0, 0, 12'hF01, 0, 0, 0, 0);
    end
    txn(0, 0, 12'h7C3, 0, 0, 0, 0);
    txn(1, 0, 12'h9C3, 32'hABCD, 0, 0, 0);

    // dropped request and spurious slave valid while waiting on slave 0
    t = cyc;
    m_rd_en = 1; m_addr = 12'h0AA;
    stb_cyc = t + 1; stb_mask = 4'b0001; stb_wr = 0; stb_addr = 8'hAA;
    e.cyc = t + 8; e.wr = 0; e.data = 32'hCAFE_F00D;
    q.push_back(e);
    @(negedge clk_ir); m_rd_en = 0;
    @(negedge clk_ir);
    m_wr_en = 1; m_addr = 12'h2AA; m_wr_data = $urandom;
    s_rd_data = {$urandom, $urandom, $urandom, $urandom}; s_rd_valid[3] = 1'b1;
    drop_m = 1; spur_m = 1;
    @(negedge clk_ir); m_wr_en = 0; s_rd_valid = '0;
    while (cyc < t + 7) @(negedge clk_ir);
    s_rd_data[0 +: DW] = 32'hCAFE_F00D; s_rd_valid[0] = 1'b1;
    @(negedge clk_ir); s_rd_valid = '0;
    while (cyc < t + 9) @(negedge clk_ir);
    txn(0, 0, 12'hF02, 0, 0, 0, 0);
    txn(1, 0, 12'hF02, 32'h3, 0, 0, 0);
    txn(0, 0, 12'hF02, 0, 0, 0, 0);

    // reset while waiting on slave 3, late slave valid after release
    t = cyc;
    m_rd_en = 1; m_addr = 12'h3C0;
    stb_cyc = t + 1; stb_mask = 4'b1000; stb_wr = 0; stb_addr = 8'hC0;
    @(negedge clk_ir); m_rd_en = 0;
    @(negedge clk_ir); rst_sync = 1'b1; model_reset();
    @(negedge clk_ir);
    chk("mid_rst_m_rd_valid", m_rd_valid === 1'b0, 64'(m_rd_valid), 0);
    chk("mid_rst_m_rd_data", m_rd_data === '0, 64'(m_rd_data), 0);
    chk("mid_rst_s_addr", s_addr === '0, 64'(s_addr), 0);
    chk("mid_rst_s_wr_data", s_wr_data === '0, 64'(s_wr_data), 0);
    @(negedge clk_ir); rst_sync = 1'b0;
    @(negedge clk_ir); s_rd_data[3*DW +: DW] = 32'h5555_AAAA; s_rd_valid[3] = 1'b1;
    @(negedge clk_ir); s_rd_valid = '0;
    repeat (4) @(negedge clk_ir);
    txn(0, 0, 12'hF02, 0, 0, 0, 0);

    for (int n = 0; n < 120; n++) begin
      int k, c, dly;
      k = $urandom_range(0, 9);
      dly = (n % 7 == 0) ? MAXD : $urandom_range(0, MAXD);
      c = $urandom_range(0, NS - 1);
      case (k)
        0, 1, 2, 3, 4: txn(1'($urandom_range(0, 1)), 0, {4'(c), 8'($urandom)}, $urandom, dly,
                           $urandom, TO_EN && k == 4);
        5: txn(1'($urandom_range(0, 1)), 0, {4'($urandom_range(NS, 14)), 8'($urandom)}, $urandom, 0, 0, 0);
        6: txn(0, 0, {4'hF, 8'($urandom_range(0, 2))}, 0, 0, 0, 0);
        7: txn(1, 0, {4'hF, 8'($urandom_range(1, 2))}, $urandom, 0, 0, 0);
        8: txn(1, 0, 12'hF00, $urandom, 0, 0, 0);
        default: txn(1, 1, {4'(c), 8'($urandom)}, $urandom, dly, 0, 0);
      endcase
    end

    repeat (6) @(negedge clk_ir);
    chk("queue_empty", q.size() == 0, 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
